// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: transmitter/receiver state encoding,
//               parity mode constants and the baud oversampling factor.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Baud-rate generator oversampling factor (s_tick pulses per bit).
  localparam int unsigned OVS = 16;

  // Parity mode selection values.
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Frame state encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART serial transmitter. Accepts one DBIT-wide word on
//               tx_start while idle and shifts out start bit, LSB-first data,
//               optional parity and SB_TICK ticks of stop level. Bit timing
//               comes from an external 16x oversampling enable (s_tick).
// Ports       : clk      - system clock, rising edge
//               reset    - asynchronous active-high reset
//               s_tick   - one-clk enable pulse at 16x baud
//               tx_start - send request, sampled only while idle
//               d_in     - word to send, captured on the accepting edge
//               tx       - registered serial line, idle high
//               tx_done  - one-clk pulse when the stop period completes
//               tx_idle  - high while idle and ready to accept
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] d_in,
  output logic            tx,
  output logic            tx_done,
  output logic            tx_idle
);

  localparam logic       C_HAS_PAR = (PARITY != PAR_NONE);
  localparam logic       C_ODD     = (PARITY == PAR_ODD);
  localparam logic [4:0] C_BIT_END = 5'(OVS - 1);
  localparam logic [4:0] C_SB_END  = 5'(SB_TICK - 1);
  localparam logic [2:0] C_LAST    = 3'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [4:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counters and datapath.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shreg_d = d_in;
          tick_d  = '0;
          bit_d   = '0;
          par_d   = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (tick_q == C_BIT_END) begin
            tick_d  = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == C_BIT_END) begin
            tick_d  = '0;
            par_d   = par_q ^ shreg_q[0];
            shreg_d = shreg_q >> 1;
            if (bit_q == C_LAST) begin
              state_d = C_HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (tick_q == C_BIT_END) begin
            tick_d  = '0;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (tick_q == C_SB_END) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The line level is decoded from the next state so the flop presents the
  // new bit on the same edge the state changes, keeping tx purely registered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d ^ C_ODD;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_idle = (state_q == ST_IDLE);

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Three instances (no parity,
//               even, odd) share stimulus; expected line levels are queued
//               when a frame is launched and popped at each bit centre.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       tx_start;
  logic [7:0] d_in;
  logic       tx0, tx1, tx2;
  logic       done0, done1, done2;
  logic       idle0, idle1, idle2;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int ndone0  = 0;

  typedef struct {
    string tag;
    logic  exp;
  } sb_t;
  sb_t sb[$];

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .d_in(d_in),
    .tx(tx0), .tx_done(done0), .tx_idle(idle0)
  );
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .d_in(d_in),
    .tx(tx1), .tx_done(done1), .tx_idle(idle1)
  );
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .d_in(d_in),
    .tx(tx2), .tx_done(done2), .tx_idle(idle2)
  );

  always #5 clk = ~clk;

  // s_tick: one clk high out of every four.
  logic [1:0] tdiv = 2'd0;
  always @(posedge clk) begin
    tdiv   <= tdiv + 2'd1;
    s_tick <= (tdiv == 2'd2);
    cyc    <= cyc + 1;
    if (done0) ndone0 <= ndone0 + 1;
  end

  function automatic logic sel_tx(input int d);
    return (d == 0) ? tx0 : ((d == 1) ? tx1 : tx2);
  endfunction

  function automatic logic sel_done(input int d);
    return (d == 0) ? done0 : ((d == 1) ? done1 : done2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(idle0 && idle1 && idle2) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) check("idle_timeout", {29'd0, idle0, idle1, idle2}, 32'd7);
  endtask

  // Launch a frame on an edge where s_tick is high, so every bit is exactly
  // 64 clk long. Returns the cycle number of the accepting edge.
  task automatic start_frame(input logic [7:0] data, input bit hold, output int t0);
    int k = 0;
    wait_idle();
    @(negedge clk);
    while (!s_tick && k < 8) begin
      @(negedge clk);
      k++;
    end
    d_in     = data;
    tx_start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    if (!hold) tx_start = 1'b0;
  endtask

  // Queue the expected levels, compare each at its bit centre, then wait for
  // tx_done. Returns at the negedge of the tx_done cycle.
  task automatic check_frame(input int dut, input logic [7:0] data, input int mode,
                             input int t0, input int inject, input int tol);
    sb_t e;
    int  nbits;
    int  k;
    int  delta;
    int  exp_len;
    sb.push_back('{"start", 1'b0});
    for (int i = 0; i < 8; i++) sb.push_back('{$sformatf("d%0d", i), data[i]});
    if (mode == 1) sb.push_back('{"par_even", ^data});
    if (mode == 2) sb.push_back('{"par_odd", ~(^data)});
    sb.push_back('{"stop", 1'b1});
    nbits   = sb.size();
    exp_len = 4 * (16 * (1 + 8 + ((mode != 0) ? 1 : 0)) + 16);
    for (int i = 0; i < nbits; i++) begin
      while (cyc < t0 + 32 + 64 * i) @(negedge clk);
      e = sb.pop_front();
      check($sformatf("dut%0d_%02h_%s", dut, data, e.tag), {31'd0, sel_tx(dut)}, {31'd0, e.exp});
      if (i == inject) begin
        d_in     = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    end
    k = 0;
    while (!sel_done(dut) && k < 1500) begin
      @(negedge clk);
      k++;
    end
    delta = cyc - t0;
    if (k >= 1500) check("done_timeout", {31'd0, sel_done(dut)}, 32'd1);
    else if (tol == 0) check($sformatf("dut%0d_done_latency", dut), delta, exp_len);
    else check($sformatf("dut%0d_done_window", dut),
               {31'd0, (delta >= exp_len - tol) && (delta <= exp_len)}, 32'd1);
  endtask

  initial begin
    int t0, t1, nd, lows, extra;
    reset    = 1'b1;
    tx_start = 1'b0;
    d_in     = 8'h00;

    // Reset state and quiet idle.
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, tx0}, 32'd1);
    check("rst_idle", {31'd0, idle0}, 32'd1);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_tx_par", {30'd0, tx1, tx2}, 32'd3);
    reset = 1'b0;
    lows  = 0;
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx0 || !idle0) lows++;
      if (done0 || done1 || done2) extra++;
    end
    check("quiet_line", lows, 0);
    check("quiet_done", extra, 0);

    // Plain frame 8'hA5, no parity.
    start_frame(8'hA5, 1'b0, t0);
    check("accept_tx_low", {31'd0, tx0}, 32'd0);
    check("accept_busy", {31'd0, idle0}, 32'd0);
    check_frame(0, 8'hA5, 0, t0, -1, 0);
    check("done_idle", {31'd0, idle0}, 32'd1);

    // Even and odd parity, 8'h07.
    start_frame(8'h07, 1'b0, t0);
    check_frame(1, 8'h07, 1, t0, -1, 0);
    start_frame(8'h07, 1'b0, t0);
    check_frame(2, 8'h07, 2, t0, -1, 0);

    // tx_start with 8'hFF mid-DATA of an 8'h00 frame is ignored.
    wait_idle();
    nd = ndone0;
    start_frame(8'h00, 1'b0, t0);
    check_frame(0, 8'h00, 0, t0, 4, 0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!tx0) lows++;
    end
    check("no_second_frame", lows, 0);
    check("single_done", ndone0 - nd, 1);

    // Back-to-back: tx_start held, next word presented in the tx_done cycle.
    start_frame(8'h55, 1'b1, t0);
    check_frame(0, 8'h55, 0, t0, -1, 0);
    d_in = 8'h3C;
    @(posedge clk);
    #1 t1 = cyc;
    check("b2b_start_tx", {31'd0, tx0}, 32'd0);
    check("b2b_busy", {31'd0, idle0}, 32'd0);
    @(negedge clk);
    tx_start = 1'b0;
    check_frame(0, 8'h3C, 0, t1, -1, 3);

    // Asynchronous reset during data bit 3.
    start_frame(8'hA5, 1'b0, t0);
    while (cyc < t0 + 32 + 64 * 4) @(negedge clk);
    check("pre_rst_bit3", {31'd0, tx0}, 32'd0);
    nd = ndone0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx0}, 32'd1);
    check("async_rst_idle", {31'd0, idle0}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (800) @(negedge clk);
    check("rst_no_done", ndone0 - nd, 0);
    start_frame(8'hC3, 1'b0, t0);
    check_frame(0, 8'hC3, 0, t0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_uart_tx
`default_nettype wire
